// File: rtl/freq_meas_ctrl_if.sv
// Bundles the operator inputs, measured signal and readout outputs of freq_meas_ctrl.
// slave: the measurement sequencer. master: whoever drives switches/sigin and reads results.
interface freq_meas_ctrl_if #(
  parameter int unsigned CNT_W = 24
);
  logic [1:0]       sw_mode;
  logic             start;
  logic             cont;
  logic             sigin;
  logic [1:0]       testmode;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] freq;
  logic             overflow;

  modport master (
    output sw_mode, start, cont, sigin,
    input  testmode, busy, done, freq, overflow
  );

  modport slave (
    input  sw_mode, start, cont, sigin,
    output testmode, busy, done, freq, overflow
  );
endinterface

// File: rtl/freq_meas_ctrl.sv
// Frequency-meter measurement sequencer: mode select, settle wait, fixed sysclk gate,
// synchronized edge count and result latch.
// Optional feature macro: AUTO_SCAN_EN (testmode steps 00..11 automatically, sw_mode ignored).
module freq_meas_ctrl #(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned GATE_CYCLES   = 100000000,
  parameter int unsigned SETTLE_CYCLES = 1024
) (
  input  logic            sysclk,
  input  logic            reset,
  freq_meas_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_GATE   = 2'd2,
    ST_LATCH  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               flag_q, flag_d;
  logic [1:0]         testmode_q, testmode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               overflow_q, overflow_d;
  logic [2:0]         sync_q, sync_d;
  logic               rise_c;
  logic [1:0]         mode_on_start_c;
  logic [1:0]         mode_on_cont_c;

  // Two synchronizer flops plus an edge-detect flop on the asynchronous input
  always_comb begin
    sync_d = {sync_q[1:0], bus.sigin};
    rise_c = sync_q[1] & ~sync_q[2];
  end

`ifdef AUTO_SCAN_EN
  logic scan_started_q, scan_started_d;

  // Remembers whether any run has started since reset, so the first run uses mode 00
  always_comb begin
    scan_started_d = scan_started_q | ((state_q == ST_IDLE) & bus.start);
  end

  // Scan-start flag register
  always_ff @(posedge sysclk) begin
    if (reset) scan_started_q <= 1'b0;
    else       scan_started_q <= scan_started_d;
  end

  // Auto scan: step the mode on every new run, wrapping 11 -> 00
  always_comb begin
    mode_on_start_c = scan_started_q ? 2'(testmode_q + 2'd1) : 2'b00;
    mode_on_cont_c  = 2'(testmode_q + 2'd1);
  end
`else
  // Manual mode: the operator switches pick the mode at every entry into SETTLE
  always_comb begin
    mode_on_start_c = bus.sw_mode;
    mode_on_cont_c  = bus.sw_mode;
  end
`endif

  // Next-state, timer, edge counter and result logic
  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    testmode_d = testmode_q;
    done_d     = 1'b0;
    freq_d     = freq_q;
    overflow_d = overflow_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          testmode_d = mode_on_start_c;
          cnt_d      = '0;
          flag_d     = 1'b0;
          tmr_d      = TMR_W'(SETTLE_CYCLES);
          state_d    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == TMR_W'(1)) begin
          tmr_d   = TMR_W'(GATE_CYCLES);
          cnt_d   = '0;
          flag_d  = 1'b0;
          state_d = ST_GATE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_GATE: begin
        if (rise_c) begin
          if (cnt_q == CNT_MAX) flag_d = 1'b1;
          else                  cnt_d  = cnt_q + CNT_W'(1);
        end
        if (tmr_q == TMR_W'(1)) state_d = ST_LATCH;
        else                    tmr_d   = tmr_q - TMR_W'(1);
      end
      ST_LATCH: begin
        freq_d     = cnt_q;
        overflow_d = flag_q;
        done_d     = 1'b1;
        if (bus.cont) begin
          testmode_d = mode_on_cont_c;
          tmr_d      = TMR_W'(SETTLE_CYCLES);
          state_d    = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers; synchronous reset discards any partial measurement
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      testmode_q <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      sync_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      testmode_q <= testmode_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      sync_q     <= sync_d;
    end
  end

  assign bus.testmode = testmode_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.freq     = freq_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// Self-checking bench for freq_meas_ctrl: a 24-bit instance (gate 4000) and a 4-bit
// instance (gate 400) share clock and reset. Expected counts come from tables and from
// a floor/ceil period model of the gate window.
module tb_freq_meas_ctrl;

  localparam int unsigned S_CYC = 16;
  localparam int unsigned G_M   = 4000;
  localparam int unsigned G_S   = 400;
  localparam int          LIM_M = 4200;
  localparam int          LIM_S = 600;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_meas_ctrl_if #(.CNT_W(24)) m_if ();
  freq_meas_ctrl_if #(.CNT_W(4))  s_if ();

  freq_meas_ctrl #(.CNT_W(24), .GATE_CYCLES(G_M), .SETTLE_CYCLES(S_CYC)) u_main (
    .sysclk (clk),
    .reset  (rst),
    .bus    (m_if.slave)
  );

  freq_meas_ctrl #(.CNT_W(4), .GATE_CYCLES(G_S), .SETTLE_CYCLES(S_CYC)) u_small (
    .sysclk (clk),
    .reset  (rst),
    .bus    (s_if.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int per_m = 0;
  int per_s = 0;
  int ph_m  = 0;
  int ph_s  = 0;

  typedef struct {
    int     d;
    int     per;
    longint f;
    longint ov;
  } vec_t;

  vec_t tbl [8];

  // Periodic sigin generators, updated a little after each rising edge
  initial begin
    m_if.sigin = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (per_m < 4) begin
        ph_m = 0; m_if.sigin = 1'b0;
      end else begin
        ph_m = (ph_m + 1 >= per_m) ? 0 : ph_m + 1;
        m_if.sigin = (ph_m < per_m / 2);
      end
    end
  end

  initial begin
    s_if.sigin = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (per_s < 4) begin
        ph_s = 0; s_if.sigin = 1'b0;
      end else begin
        ph_s = (ph_s + 1 >= per_s) ? 0 : ph_s + 1;
        s_if.sigin = (ph_s < per_s / 2);
      end
    end
  end

  // Hard stop in case something never returns
  initial begin
    #980000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check_rng(input string nm, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      if (lo == hi) $display("FAIL %s: got %0d, expected %0d", nm, act, lo);
      else          $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  function automatic longint get_done(input int d);
    return (d == 0) ? longint'(m_if.done) : longint'(s_if.done);
  endfunction

  function automatic longint get_busy(input int d);
    return (d == 0) ? longint'(m_if.busy) : longint'(s_if.busy);
  endfunction

  function automatic longint get_freq(input int d);
    return (d == 0) ? longint'(m_if.freq) : longint'(s_if.freq);
  endfunction

  function automatic longint get_ovf(input int d);
    return (d == 0) ? longint'(m_if.overflow) : longint'(s_if.overflow);
  endfunction

  function automatic longint exp_lat(input int d);
    return longint'(S_CYC) + ((d == 0) ? longint'(G_M) : longint'(G_S)) + 64'sd1;
  endfunction

  // Reference model: P-periodic edges in a G-cycle window give floor(G/P) or ceil(G/P)
  function automatic void model(input int d, input int per,
                                output longint f_lo, output longint f_hi,
                                output longint ov_lo, output longint ov_hi);
    longint g  = (d == 0) ? longint'(G_M) : longint'(G_S);
    longint mx = (d == 0) ? ((64'sd1 <<< 24) - 1) : 64'sd15;
    longint lo = g / longint'(per);
    longint hi = (g + longint'(per) - 1) / longint'(per);
    f_lo  = (lo > mx) ? mx : lo;
    f_hi  = (hi > mx) ? mx : hi;
    ov_lo = (lo > mx) ? 64'sd1 : 64'sd0;
    ov_hi = (hi > mx) ? 64'sd1 : 64'sd0;
  endfunction

  task automatic set_start(input int d, input logic v);
    if (d == 0) m_if.start = v;
    else        s_if.start = v;
  endtask

  // One-cycle start pulse; returns 1ns after the sampling edge
  task automatic pulse_start(input int d);
    @(posedge clk); #1;
    set_start(d, 1'b1);
    @(posedge clk); #1;
    set_start(d, 1'b0);
  endtask

  task automatic wait_done(input int d, output int lat);
    int lim = (d == 0) ? LIM_M : LIM_S;
    lat = 0;
    while (lat < lim) begin
      @(posedge clk); #1;
      lat++;
      if (get_done(d) == 1) break;
    end
  endtask

  task automatic run_meas(input string nm, input int d, input int per,
                          input longint f_lo, input longint f_hi,
                          input longint ov_lo, input longint ov_hi);
    int lat;
    if (d == 0) per_m = per;
    else        per_s = per;
    pulse_start(d);
    check_rng({nm, "_busy_rise"}, get_busy(d), 1, 1);
    wait_done(d, lat);
    check_rng({nm, "_latency"}, longint'(lat), exp_lat(d), exp_lat(d));
    check_rng({nm, "_freq"}, get_freq(d), f_lo, f_hi);
    check_rng({nm, "_ovf"}, get_ovf(d), ov_lo, ov_hi);
    check_rng({nm, "_busy_at_done"}, get_busy(d), 0, 0);
    @(posedge clk); #1;
    check_rng({nm, "_done_width"}, get_done(d), 0, 0);
  endtask

  initial begin
    int     lat;
    int     ndone;
    longint tm_last;
    longint f_lo, f_hi, ov_lo, ov_hi;

    tbl[0] = '{0, 40,  100, 0};
    tbl[1] = '{0, 125, 32,  0};
    tbl[2] = '{1, 4,   15,  1};
    tbl[3] = '{1, 40,  10,  0};
    tbl[4] = '{1, 25,  15,  1};
    tbl[5] = '{1, 50,  8,   0};
    tbl[6] = '{1, 8,   15,  1};
    tbl[7] = '{1, 100, 4,   0};

    rst = 1'b1;
    m_if.start = 1'b0; m_if.cont = 1'b0; m_if.sw_mode = 2'b00;
    s_if.start = 1'b0; s_if.cont = 1'b0; s_if.sw_mode = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on both instances
    for (int d = 0; d < 2; d++) begin
      check_rng("rst_busy", get_busy(d), 0, 0);
      check_rng("rst_done", get_done(d), 0, 0);
      check_rng("rst_freq", get_freq(d), 0, 0);
      check_rng("rst_ovf",  get_ovf(d),  0, 0);
    end
    check_rng("rst_testmode", longint'(m_if.testmode), 0, 0);

    // Table-driven single measurements
    for (int i = 0; i < 8; i++) begin
      run_meas($sformatf("tbl%0d", i), tbl[i].d, tbl[i].per,
               tbl[i].f, tbl[i].f, tbl[i].ov, tbl[i].ov);
    end

    // Reset 1000 cycles into GATE: everything cleared, no result ever appears
    m_if.sw_mode = 2'b10;
    per_m = 40;
    pulse_start(0);
    repeat (S_CYC + 1000) @(posedge clk);
    #1;
`ifndef AUTO_SCAN_EN
    check_rng("midrst_tm_before", longint'(m_if.testmode), 2, 2);
`endif
    check_rng("midrst_busy_before", get_busy(0), 1, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_rng("midrst_busy", get_busy(0), 0, 0);
    check_rng("midrst_freq", get_freq(0), 0, 0);
    check_rng("midrst_done", get_done(0), 0, 0);
    check_rng("midrst_ovf",  get_ovf(0),  0, 0);
    check_rng("midrst_testmode", longint'(m_if.testmode), 0, 0);
    ndone = 0;
    for (int c = 0; c < LIM_M; c++) begin
      @(posedge clk); #1;
      if (m_if.done) ndone++;
    end
    check_rng("midrst_no_done", longint'(ndone), 0, 0);

`ifdef AUTO_SCAN_EN
    // Auto scan with cont: the mode of each run (seen in its LATCH cycle) is 00,01,10,11,00
    m_if.sw_mode = 2'b11;
    m_if.cont = 1'b1;
    per_m = 40;
    pulse_start(0);
    tm_last = longint'(m_if.testmode);
    for (int r = 0; r < 5; r++) begin
      lat = 0;
      while (lat < LIM_M) begin
        @(posedge clk); #1;
        lat++;
        if (m_if.done) break;
        tm_last = longint'(m_if.testmode);
      end
      check_rng($sformatf("scan%0d_latency", r), longint'(lat), exp_lat(0), exp_lat(0));
      check_rng($sformatf("scan%0d_testmode", r), tm_last, longint'(r % 4), longint'(r % 4));
      check_rng($sformatf("scan%0d_freq", r), get_freq(0), 100, 100);
      if (r == 3) m_if.cont = 1'b0;
    end
    check_rng("scan_busy_end", get_busy(0), 0, 0);
`else
    // Manual mode: sw_mode change mid-run is ignored until the next start
    m_if.sw_mode = 2'b10;
    per_m = 40;
    pulse_start(0);
    check_rng("mode_tm_start", longint'(m_if.testmode), 2, 2);
    repeat (S_CYC + 2000) @(posedge clk);
    #1 m_if.sw_mode = 2'b01;
    check_rng("mode_tm_midgate", longint'(m_if.testmode), 2, 2);
    wait_done(0, lat);
    check_rng("mode_latency", longint'(lat), exp_lat(0) - longint'(S_CYC + 2000), exp_lat(0) - longint'(S_CYC + 2000));
    check_rng("mode_tm_done", longint'(m_if.testmode), 2, 2);
    pulse_start(0);
    check_rng("mode_tm_next", longint'(m_if.testmode), 1, 1);
    wait_done(0, lat);
    check_rng("mode_next_freq", get_freq(0), 100, 100);
`endif

    // Continuous mode with stray starts every 100 cycles during the first two runs
    m_if.cont = 1'b1;
    per_m = 80;
    pulse_start(0);
    for (int r = 0; r < 3; r++) begin
      lat = 0;
      while (lat < LIM_M) begin
        @(posedge clk); #1;
        lat++;
        m_if.start = (r < 2) && ((lat % 100) == 50);
        if (m_if.done) break;
      end
      m_if.start = 1'b0;
      check_rng($sformatf("cont%0d_latency", r), longint'(lat), exp_lat(0), exp_lat(0));
      check_rng($sformatf("cont%0d_freq", r), get_freq(0), 50, 50);
      check_rng($sformatf("cont%0d_busy", r), get_busy(0), (r < 2) ? 1 : 0, (r < 2) ? 1 : 0);
      if (r == 1) m_if.cont = 1'b0;
    end
    repeat (20) @(posedge clk);
    #1 check_rng("cont_idle_after", get_busy(0), 0, 0);

    // Randomized periods against the window model
    for (int i = 0; i < 8; i++) begin
      int d   = (i < 2) ? 0 : 1;
      int per = (d == 0) ? int'($urandom_range(4, 300)) : int'($urandom_range(4, 120));
      model(d, per, f_lo, f_hi, ov_lo, ov_hi);
      run_meas($sformatf("rnd%0d_p%0d", i, per), d, per, f_lo, f_hi, ov_lo, ov_hi);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/freq_meas_ctrl.md
# freq_meas_ctrl

Measurement sequencer for the frequency-meter design. It selects the test-signal mode, waits for the generator to settle, and opens a precise gate window of sysclk cycles. It counts synchronized rising edges of the measured signal during that window, then latches the count as the frequency result. It sits between the switch inputs and test-signal generator on one side and the display/readout logic on the other.

## Interface
- CNT_W, 24, width of edge counter and result.
- GATE_CYCLES, 100000000, gate length in sysclk cycles. Equal to the clock rate, so the result is in Hz.
- SETTLE_CYCLES, 1024, wait after a mode change before gating.
- sysclk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- sw_mode  in  2  operator mode select (00..11), manual mode only.
- start  in  1  request one measurement; level or pulse.
- cont  in  1  continuous mode; sampled in LATCH.
- sigin  in  1  measured signal, asynchronous to sysclk.
- testmode  out  2  registered mode to the test-signal generator.
- busy  out  1  high in SETTLE, GATE and LATCH.
- done  out  1  one-cycle pulse when freq is updated.
- freq  out  CNT_W  last latched edge count.
- overflow  out  1  last measurement saturated.

## Operation
- Input path:
  - sigin passes through a 2-flop synchronizer plus a third flop.
  - The rise pulse is `s2 & ~s3`.
  - Latency from a sigin edge to the rise pulse is 2–3 cycles.
- FSM states: IDLE, SETTLE, GATE, LATCH.
- IDLE:
  - busy=0.
  - When start=1: load testmode (see Configuration), clear the edge counter and overflow flag, load the timer with SETTLE_CYCLES, and go to SETTLE.
- SETTLE:
  - The timer decrements each cycle.
  - At timer==1: load the timer with GATE_CYCLES, clear the edge counter, and go to GATE.
  - Rise pulses in SETTLE are ignored.
- GATE:
  - Each cycle with a rise pulse increments the edge counter.
  - At all-ones the counter holds and the internal overflow flag sets.
  - Exactly GATE_CYCLES cycles are in GATE; then go to LATCH.
- LATCH (1 cycle):
  - Register freq←counter, overflow←flag, done←1.
  - If cont=1, reload SETTLE_CYCLES and go to SETTLE.
  - Otherwise go to IDLE.
- start is ignored while busy=1.
- sw_mode changes while busy do not affect testmode until the next IDLE→SETTLE transition.
- freq and overflow hold their values between measurements.
- Reset, including mid-measurement: state=IDLE, testmode=00, busy=0, done=0, freq=0, overflow=0, counters=0. No partial result is latched.

## Timing
- start sampled high at edge k → busy=1 from k+1.
- done=1 for exactly one cycle, SETTLE_CYCLES+GATE_CYCLES+1 cycles after k.
- freq and overflow become valid in the same cycle as done.
- Without cont: busy=0 in the same cycle done=1.
- With cont: busy stays 1. done pulses every SETTLE_CYCLES+GATE_CYCLES+1 cycles.
- testmode changes only on the IDLE→SETTLE or LATCH→SETTLE edge, so the generator always gets SETTLE_CYCLES cycles before gating.
- Count accuracy: if an integer number of sigin periods exactly fills the gate, the count is exact. Otherwise it is ±1 edge.

## Configuration
- AUTO_SCAN_EN defined:
  - testmode loads 00 at the first start after reset.
  - testmode increments (wrapping 11→00) on every LATCH→SETTLE transition.
  - A LATCH→IDLE exit keeps the current value. The next start uses testmode+1.
  - sw_mode is ignored.
- AUTO_SCAN_EN undefined:
  - testmode loads sw_mode on every transition into SETTLE.
  - No auto-increment.

## Test plan
- Reset mid-GATE: GATE_CYCLES=4000, SETTLE_CYCLES=16; start, sigin period 40, assert reset 1000 cycles into GATE → next cycle busy=0, freq=0, done=0, testmode=00. No done pulse follows.
- Basic count: same parameters, start pulse → done exactly 4017 cycles after the start edge, freq=100, overflow=0, busy falls with done.
- Saturation: CNT_W=4, sigin period 4, GATE_CYCLES=400 → freq=15, overflow=1. A following run with period 40 gives freq=10, overflow=0.
- Continuous plus start-while-busy: cont=1, sigin period 80, start pulses every 100 cycles → done every 4017 cycles, each freq=50, extra starts have no effect.
- Mode select, AUTO_SCAN_EN undefined: sw_mode=10 at start, changed to 01 mid-GATE → testmode=10 for the whole run; the next start gives testmode=01.
- Auto scan, AUTO_SCAN_EN defined, cont=1: testmode sequence over successive done pulses is 00,01,10,11,00.
